// File: rtl/clk_en_sequencer.sv
// Clock-enable sequencer: lock-qualified reset release plus
// N_CH programmable clock-enable strobes from one fast clock.
module clk_en_sequencer #(
   parameter int N_CH        = 4,
   parameter int DIV_W       = 16,
   parameter int DIV_DEFAULT = 2,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE_CYC  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_locked_i,
   input  logic [N_CH*DIV_W-1:0] div_i,
   input  logic                  div_load,
   output logic [N_CH-1:0]       en_o,
   output logic                  rst_out,
   output logic                  ready
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   typedef enum logic [1:0] {
      WAIT_LOCK,
      SETTLE,
      RUN
   } state_t;

   state_t                 state_q, state_d;
   logic [SW-1:0]          set_q, set_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rst_out_q;
   logic                   ready_q;
   logic                   lock_s;
   logic                   run_now;
   logic                   run_next;

   assign lock_s   = sync_q[SYNC_STAGES-1];
   assign run_now  = (state_q == RUN);
   assign run_next = (state_d == RUN);
   assign rst_out  = rst_out_q;
   assign ready    = ready_q;

   // Bring the asynchronous lock indication into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   // Next-state decode: lock must stay high SETTLE_CYC cycles to run.
   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      unique case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = SETTLE;
               set_d   = '0;
            end
         end
         SETTLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               set_d   = '0;
            end else if (set_q == SETTLE_LAST) begin
               state_d = RUN;
            end else begin
               set_d = set_q + SW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            set_d   = '0;
         end
      endcase
   end

   // State, settle counter and registered reset/ready outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= WAIT_LOCK;
         set_q     <= '0;
         rst_out_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         set_q     <= set_d;
         rst_out_q <= !run_next;
         ready_q   <= run_next;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [DIV_W-1:0] div_q;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic             hit;

      assign hit = (div_q <= DIV_ONE) ||
                   (cnt_q == div_q - DIV_ONE);

      assign en_o[c] = run_now && hit;

      // Phase counter: held at zero outside RUN, cleared on load.
      always_comb begin
         cnt_d = cnt_q + DIV_ONE;
         if (div_load || !run_now || !run_next || hit) begin
            cnt_d = '0;
         end
      end

      // Divisor and phase registers for this channel.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            div_q <= DIV_RST;
            cnt_q <= '0;
         end else begin
            if (div_load) begin
               div_q <= div_i[c*DIV_W +: DIV_W];
            end
            cnt_q <= cnt_d;
         end
      end
   end

endmodule
